// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared sizes, timeout length and FSM state type for mem_arbiter
package mem_arb_pkg;

    localparam int NUM_REQ        = 4;
    localparam int ADDR_W         = 4;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int REQ_IDX_W      = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - memory-side request/ready bus between mem_arbiter and the memory
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              mem_req_o;
    logic              mem_rnw_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot selector with last-grant pointer (requester 0 wins after reset)
module rr_arbiter
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               update_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [REQ_IDX_W-1:0] last_q;
    logic [REQ_IDX_W-1:0] last_d;
    logic [REQ_IDX_W-1:0] idx;
    logic [REQ_IDX_W-1:0] pick;
    logic                 found;

    // NUM_REQ is a power of two, so index wrap-around is plain truncation.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        pick    = last_q;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = last_q + REQ_IDX_W'(off);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        if (found) begin
            grant_o[pick] = 1'b1;
        end
        last_d = (update_i && found) ? pick : last_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= REQ_IDX_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - 4-requester round-robin memory arbiter; WAIT timeout enabled by MEM_ARB_TIMEOUT_EN
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0]             req_rnw_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]             req_done_o,
    output logic [NUM_REQ-1:0]             req_err_o,
    output logic [DATA_W-1:0]              req_rdata_o,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           busy_o,
    mem_arbiter_if.master                  mem
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic               rnw_q, rnw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic [NUM_REQ-1:0] rr_grant;
    logic               rr_update;
    logic               sel_rnw;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    rr_arbiter u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_valid_i),
        .update_i (rr_update),
        .grant_o  (rr_grant)
    );

    always_comb begin
        sel_rnw   = 1'b1;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_grant[i]) begin
                sel_rnw   = req_rnw_i[i];
                sel_addr  = req_addr_i[i];
                sel_wdata = req_wdata_i[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rr_update = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    rr_update = 1'b1;
                    owner_d   = rr_grant;
                    rnw_d     = sel_rnw;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    state_d   = ST_ISSUE;
                end
            end
            // ready may still be high from the previous access, so it is not looked at here
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
            end
            ST_WAIT: begin
                if (mem.mem_ready_i) begin
                    if (rnw_q) begin
                        rdata_d = mem.mem_rdata_i;
                    end
                    state_d = ST_GAP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rnw_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Every output is decoded from registered state so reset clears it without waiting for a clock.
    assign busy_o          = (state_q != ST_IDLE);
    assign grant_o         = busy_o ? owner_q : '0;
    assign req_done_o      = (state_q == ST_GAP) ? owner_q : '0;
    assign req_rdata_o     = rdata_q;
    assign mem.mem_req_o   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign mem.mem_rnw_o   = rnw_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
    assign req_err_o = ((state_q == ST_GAP) && err_q) ? owner_q : '0;
`else
    assign req_err_o = '0;
`endif

endmodule
